// File: rtl/fx2fp16_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fx2fp16_pipe                                                    |
// | Function : 3-stage two's-complement fixed-point to IEEE binary16 converter |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fx2fp16_pipe #(
  parameter int IN_W     = 16,
  parameter int FRAC_W   = 0,
  parameter int SAT_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] fixed_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     float_out,
  output logic [2:0]      out_flags
);

  // Fraction bits below the leading one plus 12 zero bits so guard/sticky exist for small p
  localparam int c_norm_w = IN_W + 11;

  logic w_adv;

  // Stage 1: sign / magnitude
  logic            w_sign;
  logic [IN_W-1:0] w_mag;
  logic            r1_valid;
  logic            r1_sign;
  logic [IN_W-1:0] r1_mag;

  // Stage 2: leading-one detect / normalise
  logic [5:0]          w_lead;
  logic [5:0]          w_shamt;
  logic                w_zero;
  logic [c_norm_w-1:0] w_ext;
  logic [c_norm_w-1:0] w_norm;
  logic signed [7:0]   w_exp;
  logic                r2_valid;
  logic                r2_sign;
  logic                r2_zero;
  logic signed [7:0]   r2_exp;
  logic [9:0]          r2_mant;
  logic                r2_guard;
  logic                r2_sticky;

  // Stage 3: round / pack
  logic              w_inc;
  logic [10:0]       w_mant_rnd;
  logic signed [7:0] w_exp_rnd;
  logic              w_unf;
  logic              w_ovf;
  logic [15:0]       w_float;
  logic [2:0]        w_flags;
  logic              r3_valid;
  logic [15:0]       r3_float;
  logic [2:0]        r3_flags;

  assign w_adv    = ~r3_valid | out_ready;
  assign in_ready = w_adv;

  assign w_sign = fixed_in[IN_W-1];
  assign w_mag  = w_sign ? (IN_W'(0) - fixed_in) : fixed_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_mag   <= '0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r1_sign  <= w_sign;
      r1_mag   <= w_mag;
    end
  end

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (r1_mag[i]) w_lead = 6'(i);
    end
  end

  // The leading one itself is dropped: shifting left moves it out of the top
  assign w_zero  = ~|r1_mag;
  assign w_shamt = 6'(IN_W - 1) - w_lead;
  assign w_ext   = {r1_mag[IN_W-2:0], 12'b0};
  assign w_norm  = w_ext << w_shamt;
  assign w_exp   = 8'(w_lead) - 8'(FRAC_W) + 8'd15;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_sign   <= 1'b0;
      r2_zero   <= 1'b0;
      r2_exp    <= '0;
      r2_mant   <= '0;
      r2_guard  <= 1'b0;
      r2_sticky <= 1'b0;
    end else if (w_adv) begin
      r2_valid  <= r1_valid;
      r2_sign   <= r1_sign;
      r2_zero   <= w_zero;
      r2_exp    <= w_exp;
      r2_mant   <= w_norm[c_norm_w-1 -: 10];
      r2_guard  <= w_norm[c_norm_w-11];
      r2_sticky <= |w_norm[c_norm_w-12:0];
    end
  end

  // Round to nearest even; a carry out leaves mantissa bits [9:0] at zero
  assign w_inc      = r2_guard & (r2_mant[0] | r2_sticky);
  assign w_mant_rnd = {1'b0, r2_mant} + 11'(w_inc);
  assign w_exp_rnd  = r2_exp + $signed({7'b0, w_mant_rnd[10]});
  assign w_unf      = r2_exp < 8'sd1;
  assign w_ovf      = w_exp_rnd > 8'sd30;

  always_comb begin
    w_float = {r2_sign, w_exp_rnd[4:0], w_mant_rnd[9:0]};
    w_flags = {2'b00, r2_guard | r2_sticky};
    if (r2_zero) begin
      w_float = 16'h0000;
      w_flags = 3'b000;
    end else if (w_unf) begin
      w_float = {r2_sign, 15'h0000};
      w_flags = 3'b010;
    end else if (w_ovf) begin
      w_float = (SAT_MODE != 0) ? {r2_sign, 15'h7BFF} : {r2_sign, 15'h7C00};
      w_flags = 3'b100;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid <= 1'b0;
      r3_float <= '0;
      r3_flags <= '0;
    end else if (w_adv) begin
      r3_valid <= r2_valid;
      r3_float <= w_float;
      r3_flags <= w_flags;
    end
  end

  assign out_valid = r3_valid;
  assign float_out = r3_float;
  assign out_flags = r3_flags;

endmodule
`default_nettype wire

// File: doc/fx2fp16_pipe.md
FX2FP16_PIPE -- requirements
Module: fx2fp16_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, giving the fixed-point input width, legal range 8..32.
REQ-002 The block SHALL have parameter FRAC_W, default 0, giving the number of fractional input bits, legal range 0..IN_W-1.
REQ-003 The block SHALL have parameter SAT_MODE, default 0: 0 = overflow yields ±infinity, 1 = overflow yields ±max finite (0x7BFF/0xFBFF).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, input sample valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit, block accepts a sample this cycle.
REQ-008 The block SHALL have port fixed_in, input, IN_W bits, two's-complement fixed-point sample.
REQ-009 The block SHALL have port out_valid, output, 1 bit, result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, downstream accepts result.
REQ-011 The block SHALL have port float_out, output, 16 bits, IEEE-754 binary16 result.
REQ-012 The block SHALL have port out_flags, output, 3 bits, {overflow, underflow, inexact} for float_out.

Function
REQ-013 The block SHALL be a 3-stage pipeline: S1 sign/magnitude, S2 leading-one detect + normalise, S3 round + pack.
REQ-014 The pipeline SHALL advance when adv = ~S3_valid | out_ready; in_ready SHALL equal adv combinationally.
REQ-015 A sample SHALL be accepted on a cycle with in_valid & in_ready; with out_ready held high, the result SHALL appear on out_valid exactly 3 cycles after acceptance, one result per cycle.
REQ-016 When adv=0, all stage registers, float_out and out_flags SHALL hold; no sample is dropped or duplicated.
REQ-017 Magnitude SHALL be computed in IN_W bits unsigned, so -2^(IN_W-1) converts correctly.
REQ-018 For leading-one position p, the biased exponent SHALL be E = p - FRAC_W + 15.
REQ-019 The 10 bits below the leading one SHALL form the mantissa, with guard = next bit and sticky = OR of all remaining bits (zero-filled when p<11).
REQ-020 Rounding SHALL be round-to-nearest-even; a mantissa carry out SHALL increment E and clear the mantissa.
REQ-021 inexact SHALL be set when guard|sticky=1 and the result is not zero or overflowed.
REQ-022 After rounding, E>30 SHALL set overflow and output per SAT_MODE with the input sign.
REQ-023 Pre-rounding E<1 SHALL set underflow and output signed zero (0x0000/0x8000); subnormals are not produced.
REQ-024 Input 0 SHALL yield 0x0000 with all flags 0.

Reset
REQ-025 While rst_n=0, all stage valid bits, out_valid, float_out and out_flags SHALL be 0 immediately, independent of clk.
REQ-026 in_ready SHALL be 1 during and after reset, since out_valid=0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight samples; the first accepted sample after release SHALL emerge 3 cycles later.

Verification
REQ-028 Default parameters, stream 0x0001, 0xFFFF, 0x8000, 0x0000 with out_ready=1 -> 0x3C00, 0xBC00, 0xF800, 0x0000 on 4 consecutive cycles starting 3 cycles after the first accept; flags 0.
REQ-029 Default parameters, rounding: 0x0801 -> 0x6800 (tie to even, inexact=1); 0x0803 -> 0x6802 (inexact=1); 0x7FFF -> 0x7800 (mantissa carry, inexact=1).
REQ-030 IN_W=24, 0x00FFF0 -> 0x7C00 with overflow=1 when SAT_MODE=0; -> 0x7BFF with overflow=1 when SAT_MODE=1.
REQ-031 IN_W=16, FRAC_W=15: 0x0001 -> 0x0000 with underflow=1; 0x0002 -> 0x0400; 0xFFFE -> 0x8400.
REQ-032 Backpressure: fill the pipe, drop out_ready for 5 cycles -> in_ready=0, outputs stable; then raise out_ready -> all results delivered in order, none lost.
REQ-033 Assert rst_n low with 3 samples in flight -> out_valid=0 at once; after release, a new sample yields exactly one result 3 cycles later.
